// File: rtl/dwt_up_arb.sv
// rtl/dwt_up_arb.sv - round-robin two-source arbiter feeding a 2x zero-insertion upsampler
// Each accepted coefficient is emitted as a saturated sample slot followed by a zero slot.
module dwt_up_arb #(
   parameter int W_IN      = 40,
   parameter int W_OUT     = 25,
   parameter int FRAME_LEN = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             lo_valid,
   input  logic [W_IN-1:0]  lo_data,
   output logic             lo_ready,
   input  logic             hi_valid,
   input  logic [W_IN-1:0]  hi_data,
   output logic             hi_ready,
   output logic             up_valid,
   output logic [W_OUT-1:0] up_data,
   output logic             up_phase,
   output logic             up_src,
   output logic             up_last
);

   localparam int            CW       = $clog2(FRAME_LEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      ZERO   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            grant;
   logic            pick_hi;
   logic [W_IN-1:0] lat_data;
   logic            lat_src;
   logic            lat_last;
   logic [CW-1:0]   cnt_lo;
   logic [CW-1:0]   cnt_hi;
   logic            prio_hi;

   // Out of range whenever the bits above the output sign bit disagree with it.
   function automatic logic [W_OUT-1:0] sat(input logic [W_IN-1:0] v);
      logic [W_IN-W_OUT:0] top;
      top = v[W_IN-1:W_OUT-1];
      if (top == '0 || top == '1)
         sat = v[W_OUT-1:0];
      else if (v[W_IN-1])
         sat = {1'b1, {(W_OUT-1){1'b0}}};
      else
         sat = {1'b0, {(W_OUT-1){1'b1}}};
   endfunction

   assign pick_hi = hi_valid && (!lo_valid || prio_hi);

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      case (state)
         IDLE, ZERO: begin
            grant     = !rst && en && (lo_valid || hi_valid);
            state_nxt = grant ? SAMPLE : IDLE;
         end
         SAMPLE:  state_nxt = ZERO;
         default: state_nxt = IDLE;
      endcase
      lo_ready = grant && !pick_hi;
      hi_ready = grant && pick_hi;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         lat_data <= '0;
         lat_src  <= 1'b0;
         lat_last <= 1'b0;
         cnt_lo   <= '0;
         cnt_hi   <= '0;
         prio_hi  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            lat_data <= pick_hi ? hi_data : lo_data;
            lat_src  <= pick_hi;
            if (pick_hi) begin
               lat_last <= (cnt_hi == CNT_LAST);
               cnt_hi   <= cnt_hi + CNT_ONE;
            end else begin
               lat_last <= (cnt_lo == CNT_LAST);
               cnt_lo   <= cnt_lo + CNT_ONE;
            end
            // Priority only rotates when both sources actually contended.
            if (lo_valid && hi_valid)
               prio_hi <= !pick_hi;
         end
      end
   end

   always_comb begin
      up_valid = (state == SAMPLE) || (state == ZERO);
      up_phase = (state == ZERO);
      up_src   = up_valid && lat_src;
      up_last  = (state == ZERO) && lat_last;
      up_data  = (state == SAMPLE) ? sat(lat_data) : '0;
   end

endmodule

// File: tb/tb_dwt_up_arb.sv
// tb/tb_dwt_up_arb.sv - self-checking bench for dwt_up_arb
// Fixed vector table, directed corner sequences and a slot-queue reference model.
module tb_dwt_up_arb;

   localparam int W_IN  = 40;
   localparam int W_OUT = 25;
   localparam int FL    = 4;

   localparam logic [W_IN-1:0] P30 = 40'sd1073741824;
   localparam logic [W_IN-1:0] N30 = -40'sd1073741824;
   localparam logic [W_IN-1:0] Z   = '0;

   logic             clk = 1'b0;
   logic             rst, en, lo_valid, hi_valid;
   logic [W_IN-1:0]  lo_data, hi_data;
   logic             lo_ready, hi_ready, up_valid, up_phase, up_src, up_last;
   logic [W_OUT-1:0] up_data;

   always #5 clk = ~clk;

   dwt_up_arb #(.W_IN(W_IN), .W_OUT(W_OUT), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst(rst), .en(en),
      .lo_valid(lo_valid), .lo_data(lo_data), .lo_ready(lo_ready),
      .hi_valid(hi_valid), .hi_data(hi_data), .hi_ready(hi_ready),
      .up_valid(up_valid), .up_data(up_data), .up_phase(up_phase),
      .up_src(up_src), .up_last(up_last)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit v; bit ph; bit src; bit last; longint data;
   } slot_t;

   slot_t  m_cur;
   slot_t  m_q[$];
   int     m_cnt[2];
   bit     m_prio_hi;

   bit     s_lr, s_hr, s_uv, s_ph, s_src, s_last;
   longint s_ud;

   typedef struct {
      bit rst; bit en; bit lv; logic [W_IN-1:0] ld; bit hv; logic [W_IN-1:0] hd;
      bit e_lr; bit e_hr; bit e_uv; int e_ud; bit e_ph; bit e_src; bit e_last;
   } vec_t;

   vec_t tbl[10];

   function automatic longint sat_ref(input longint v);
      longint lim;
      lim = longint'(1) <<< (W_OUT - 1);
      if (v > lim - 1) return lim - 1;
      if (v < -lim) return -lim;
      return v;
   endfunction

   function automatic logic [W_IN-1:0] rnd_data();
      logic [63:0] r;
      longint      v;
      case ($urandom % 3)
         0: v = longint'($urandom_range(0, 1 << 25)) - (longint'(1) << 24);
         1: begin
            r = {$urandom, $urandom};
            v = longint'(r);
         end
         default: v = longint'($urandom_range(0, 4095)) - 2048 +
                      (($urandom % 2 == 1) ? 16777215 : -16777216);
      endcase
      return v[W_IN-1:0];
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input bit r, input bit e, input bit lv, input logic [W_IN-1:0] ld,
                       input bit hv, input logic [W_IN-1:0] hd, input bit use_model);
      bit     grant, win_hi, last;
      int     idx;
      longint d;
      rst = r; en = e; lo_valid = lv; lo_data = ld; hi_valid = hv; hi_data = hd;
      @(negedge clk);
      s_lr = lo_ready; s_hr = hi_ready; s_uv = up_valid; s_ph = up_phase;
      s_src = up_src; s_last = up_last; s_ud = longint'($signed(up_data));
      grant  = !r && e && (lv || hv) && (!m_cur.v || m_cur.ph);
      win_hi = hv && (!lv || m_prio_hi);
      if (use_model) begin
         chk("model lo_ready", s_lr, grant && !win_hi);
         chk("model hi_ready", s_hr, grant && win_hi);
         chk("model up_valid", s_uv, m_cur.v);
         chk("model up_data", s_ud, m_cur.data);
         chk("model up_phase", s_ph, m_cur.ph);
         chk("model up_src", s_src, m_cur.src);
         chk("model up_last", s_last, m_cur.last);
      end
      if (r) begin
         m_q.delete();
         m_cur     = '{0, 0, 0, 0, 0};
         m_cnt[0]  = 0;
         m_cnt[1]  = 0;
         m_prio_hi = 1'b0;
      end else begin
         if (grant) begin
            idx  = win_hi ? 1 : 0;
            d    = win_hi ? longint'($signed(hd)) : longint'($signed(ld));
            last = (m_cnt[idx] == FL - 1);
            m_cnt[idx] = (m_cnt[idx] + 1) % FL;
            m_q.push_back('{1'b1, 1'b0, win_hi, 1'b0, sat_ref(d)});
            m_q.push_back('{1'b1, 1'b1, win_hi, last, 0});
            if (lv && hv) m_prio_hi = !win_hi;
         end
         if (m_q.size() > 0) m_cur = m_q.pop_front();
         else m_cur = '{0, 0, 0, 0, 0};
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, Z, 1'b0, Z, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      int g[8];
      logic [W_IN-1:0] d;
      m_cur = '{0, 0, 0, 0, 0};
      m_cnt[0] = 0; m_cnt[1] = 0; m_prio_hi = 1'b0;
      rst = 1'b1; en = 1'b0; lo_valid = 1'b0; hi_valid = 1'b0; lo_data = Z; hi_data = Z;
      @(posedge clk); #1;
      tick(1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0);
      tick(1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0);

      // rst, en, lv, ld, hv, hd | lo_rdy, hi_rdy, uv, ud, ph, src, last
      tbl[0] = '{1'b1, 1'b1, 1'b1, 40'd5,   1'b1, 40'd7, 1'b0, 1'b0, 1'b0, 0,         1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 40'd100, 1'b0, Z,     1'b1, 1'b0, 1'b0, 0,         1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, Z,       1'b0, Z,     1'b0, 1'b0, 1'b1, 100,       1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, Z,       1'b0, Z,     1'b0, 1'b0, 1'b1, 0,         1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 1'b0, Z,       1'b1, P30,   1'b0, 1'b1, 1'b0, 0,         1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, Z,       1'b1, N30,   1'b0, 1'b0, 1'b1, 16777215,  1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 1'b0, Z,       1'b1, N30,   1'b0, 1'b1, 1'b1, 0,         1'b1, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 1'b1, 1'b0, Z,       1'b0, Z,     1'b0, 1'b0, 1'b1, -16777216, 1'b0, 1'b1, 1'b0};
      tbl[8] = '{1'b0, 1'b1, 1'b0, Z,       1'b0, Z,     1'b0, 1'b0, 1'b1, 0,         1'b1, 1'b1, 1'b0};
      tbl[9] = '{1'b0, 1'b1, 1'b0, Z,       1'b0, Z,     1'b0, 1'b0, 1'b0, 0,         1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 10; i++) begin
         tick(tbl[i].rst, tbl[i].en, tbl[i].lv, tbl[i].ld, tbl[i].hv, tbl[i].hd, 1'b0);
         chk($sformatf("row%0d lo_ready", i), s_lr, tbl[i].e_lr);
         chk($sformatf("row%0d hi_ready", i), s_hr, tbl[i].e_hr);
         chk($sformatf("row%0d up_valid", i), s_uv, tbl[i].e_uv);
         chk($sformatf("row%0d up_data", i), s_ud, longint'(tbl[i].e_ud));
         chk($sformatf("row%0d up_phase", i), s_ph, tbl[i].e_ph);
         chk($sformatf("row%0d up_src", i), s_src, tbl[i].e_src);
         chk($sformatf("row%0d up_last", i), s_last, tbl[i].e_last);
      end

      // Both sources held valid: alternating grants, gap-free output.
      tick(1'b1, 1'b1, 1'b0, Z, 1'b0, Z, 1'b1);
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b1, 1'b1, rnd_data(), 1'b1, rnd_data(), 1'b1);
         g[i] = s_hr ? 1 : (s_lr ? 0 : 2);
         if (i >= 1) chk("pingpong up_valid", s_uv, 1);
      end
      for (int i = 0; i < 4; i++) begin
         chk("pingpong grant", g[2*i], i % 2);
         chk("pingpong no grant in sample", g[2*i+1], 2);
      end
      idle_ticks(3);

      // Frame boundary on the low-pass source.
      tick(1'b1, 1'b1, 1'b0, Z, 1'b0, Z, 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick(1'b0, 1'b1, 1'b1, W_IN'(k + 1), 1'b0, Z, 1'b1);
         chk("frame accept", s_lr, 1);
         idle_ticks(2);
         chk("frame zero phase", s_ph, 1);
         chk("frame up_last", s_last, k == 3);
      end
      idle_ticks(1);

      // en dropped during the sample slot.
      tick(1'b1, 1'b1, 1'b0, Z, 1'b0, Z, 1'b1);
      d = rnd_data();
      tick(1'b0, 1'b1, 1'b1, d, 1'b0, Z, 1'b1);
      chk("en_drop accept", s_lr, 1);
      tick(1'b0, 1'b0, 1'b1, d, 1'b0, Z, 1'b1);
      chk("en_drop sample ready", s_lr, 0);
      tick(1'b0, 1'b0, 1'b1, d, 1'b0, Z, 1'b1);
      chk("en_drop zero valid", s_uv, 1);
      chk("en_drop zero phase", s_ph, 1);
      chk("en_drop zero ready", s_lr, 0);
      tick(1'b0, 1'b0, 1'b1, d, 1'b0, Z, 1'b1);
      chk("en_drop idle valid", s_uv, 0);
      chk("en_drop idle ready", s_lr, 0);
      idle_ticks(2);

      // Reset during the sample slot aborts the pair and restores priority and counters.
      tick(1'b1, 1'b1, 1'b0, Z, 1'b0, Z, 1'b1);
      tick(1'b0, 1'b1, 1'b1, rnd_data(), 1'b1, rnd_data(), 1'b1);
      chk("rst_mid first grant lo", s_lr, 1);
      tick(1'b1, 1'b1, 1'b0, Z, 1'b0, Z, 1'b1);
      chk("rst_mid sample shown", s_uv, 1);
      chk("rst_mid ready in reset", s_lr | s_hr, 0);
      tick(1'b0, 1'b1, 1'b1, W_IN'(11), 1'b1, W_IN'(22), 1'b1);
      chk("rst_mid no zero slot", s_uv, 0);
      chk("rst_mid priority lo", s_lr, 1);
      idle_ticks(2);
      chk("rst_mid up_last", s_last, 0);
      for (int k = 1; k < 4; k++) begin
         tick(1'b0, 1'b1, 1'b1, W_IN'(k), 1'b0, Z, 1'b1);
         idle_ticks(2);
         chk("rst_mid counter last", s_last, k == 3);
      end

      // Randomized traffic against the slot-queue model.
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom % 50) == 0, ($urandom % 8) != 0, ($urandom % 10) < 7, rnd_data(),
              ($urandom % 10) < 7, rnd_data(), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dwt_up_arb.md
DWT_UP_ARB -- requirements
Module: dwt_up_arb

Interface
REQ-001 The block SHALL have parameter W_IN, default 40, meaning the signed input coefficient width.
REQ-002 The block SHALL have parameter W_OUT, default 25, meaning the signed output sample width (W_OUT < W_IN).
REQ-003 The block SHALL have parameter FRAME_LEN, default 256, meaning the number of accepted samples per source per frame (power of two, >= 2).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 rst, input, 1: synchronous active-high reset.
REQ-007 en, input, 1: permits new accepts when high.
REQ-008 lo_valid, input, 1: low-pass source has a coefficient.
REQ-009 lo_data, input, W_IN: low-pass coefficient, signed.
REQ-010 lo_ready, output, 1: low-pass coefficient accepted this cycle.
REQ-011 hi_valid, input, 1: high-pass source has a coefficient.
REQ-012 hi_data, input, W_IN: high-pass coefficient, signed.
REQ-013 hi_ready, output, 1: high-pass coefficient accepted this cycle.
REQ-014 up_valid, output, 1: up_data is valid this cycle.
REQ-015 up_data, output, W_OUT: upsampled output sample, signed.
REQ-016 up_phase, output, 1: 0 = sample slot, 1 = inserted zero slot.
REQ-017 up_src, output, 1: 0 = low-pass, 1 = high-pass owner of the current slot.
REQ-018 up_last, output, 1: final slot of a source's frame.

Function
REQ-019 The block SHALL implement states IDLE, SAMPLE and ZERO.
REQ-020 The block SHALL treat a cycle in IDLE or ZERO as a grant cycle if en=1 and at least one source has valid=1.
REQ-021 In a grant cycle, the block SHALL assert exactly one ready (combinationally), latch that source's data and ID, and move to SAMPLE; otherwise IDLE->IDLE and ZERO->IDLE.
REQ-022 The block SHALL move from SAMPLE to ZERO unconditionally, and SHALL never assert any ready in SAMPLE.
REQ-023 The arbitration SHALL be round-robin: if only one source is valid, that source wins; if both are valid, the source with priority wins, and priority then passes to the other source.
REQ-024 In SAMPLE, outputs SHALL be registered: up_valid=1, up_phase=0, up_src=latched ID, up_data=sat(latched data).
REQ-025 In ZERO: up_valid=1, up_phase=1, up_src=latched ID, up_data=0.
REQ-026 In IDLE: up_valid=0, up_data=0, up_phase=0, up_src=0, up_last=0.
REQ-027 The sat() function SHALL map values > 2^(W_OUT-1)-1 to 2^(W_OUT-1)-1, map values < -2^(W_OUT-1) to -2^(W_OUT-1), and pass all other values through unchanged in the low W_OUT bits.
REQ-028 Latency SHALL be: accept at cycle N, sample slot at N+1, zero slot at N+2.
REQ-029 Peak throughput SHALL be one accept per two cycles, with back-to-back pairs when valid is held.
REQ-030 The block SHALL keep independent per-source sample counters that increment on that source's accept and wrap from FRAME_LEN-1 to 0.
REQ-031 The block SHALL assert up_last only in the ZERO slot of the sample that was accepted when that source's counter was FRAME_LEN-1.
REQ-032 en=0 SHALL block new grants only; a pair already in progress SHALL complete both slots.
REQ-033 A ready signal SHALL never be asserted while its valid is low.

Reset
REQ-034 While rst=1, next state SHALL be IDLE, both counters 0, priority to low-pass, and the latched data/ID cleared.
REQ-035 While rst=1, ready outputs SHALL be 0 in the same cycle, and all registered outputs SHALL be 0 from the following cycle.
REQ-036 When rst is asserted mid-pair, the pair SHALL be aborted: no ZERO slot is emitted and there is no up_last.

Verification
REQ-037 The bench SHALL cover: only lo_valid=1 with lo_data=100 at cycle 0 -> lo_ready=1 @0; up_data=100, up_phase=0 @1; up_data=0, up_phase=1 @2; up_src=0 on both slots.
REQ-038 The bench SHALL cover: both valid held for 8 cycles -> grant sequence lo, hi, lo, hi at cycles 0, 2, 4, 6, with up_valid continuously 1 from cycle 1.
REQ-039 The bench SHALL cover: hi_data=+2^30, then -2^30 (W_IN=40, W_OUT=25) -> up_data=16777215 and then -16777216.
REQ-040 The bench SHALL cover: FRAME_LEN=4, 4 low-pass accepts -> up_last=1 only on the 4th low-pass ZERO slot; a 5th accept gives up_last=0.
REQ-041 The bench SHALL cover: en dropped in the SAMPLE cycle while valid is held -> ZERO slot still emitted, no ready afterwards, then IDLE.
REQ-042 The bench SHALL cover: rst in the SAMPLE cycle -> next cycle up_valid=0, counters 0, priority to low-pass.
